mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline. It allows a single outstanding transaction on a variable-latency req/ack memory bus. Data accesses have priority over fetches, with a starvation guard for fetches. It produces stall_if/stall_mem for the hazard detection unit and discards fetches that a redirect flush has killed.

Parameters:
TIMEOUT_CYC, 0, cycles spent waiting for mem_ack before the transaction is aborted; 0 disables the timeout.
FETCH_STARVE, 4, maximum consecutive data grants while if_req is pending; the next grant is then forced to fetch.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
if_req  in  1  fetch request, held until if_valid
if_addr  in  32  fetch address
if_flush  in  1  redirect; kills the pending or in-flight fetch
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle pulse, fetch complete
dm_req  in  1  data request, held until dm_done
dm_we  in  1  1 = store
dm_addr  in  32  data address
dm_wdata  in  32  store data
dm_be  in  4  byte enables
dm_rdata  out  32  load data
dm_done  out  1  one-cycle pulse, data access complete
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables
mem_ack  in  1  one-cycle completion from memory
mem_rdata  in  32  read data, valid with mem_ack
stall_if  out  1  combinational: if_req & ~if_valid
stall_mem  out  1  combinational: dm_req & ~dm_done
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Clock and reset: clk; synchronous active-low reset rstn.
- Reset values:
  - State is IDLE; both counters are 0.
  - mem_req, mem_we, if_valid, dm_done and bus_err are 0.
  - mem_addr, mem_wdata, mem_be, if_rdata and dm_rdata are 0.
- Reset asserted mid-transaction drops mem_req immediately. The memory model must tolerate this.
- States: IDLE, DATA, FETCH, FETCH_DROP.
- IDLE grant, evaluated every cycle:
  - If dm_req and (starve_cnt < FETCH_STARVE or ~if_req or if_flush): grant data. Latch dm_* into mem_* and go to DATA.
  - Else if if_req and ~if_flush: grant fetch. Latch if_addr, set mem_we=0 and mem_be=4'hF, go to FETCH.
  - Else stay in IDLE.
- Starvation counter (starve_cnt):
  - Increments on each data grant while if_req=1, saturating at FETCH_STARVE.
  - Clears on any fetch grant.
  - Clears on a data grant with if_req=0.
- mem_req is registered. It rises the cycle after the grant and stays high, with address, data and byte enables stable, until mem_ack.
- DATA state, on mem_ack:
  - Next cycle: dm_done=1. If ~dm_we, dm_rdata is loaded from mem_rdata; on stores dm_rdata holds its previous value.
  - mem_req goes low and the state returns to IDLE.
- FETCH state:
  - on mem_ack & ~if_flush: next cycle if_valid=1, if_rdata is loaded from mem_rdata, state returns to IDLE.
  - on if_flush & ~mem_ack: go to FETCH_DROP. mem_req stays high because a transaction cannot be aborted.
  - on if_flush & mem_ack in the same cycle: the response is discarded (no if_valid) and the state returns to IDLE.
- FETCH_DROP state: wait for mem_ack, discard the data, return to IDLE. No if_valid is generated.
- Latency with a zero-wait memory (ack in the first mem_req cycle):
  - Request seen in cycle 0; mem_req in cycle 1; done/valid in cycle 2.
  - A new grant is possible in cycle 2, giving back-to-back throughput of 1 access per 2 cycles.
- Timeout (only when TIMEOUT_CYC > 0):
  - wait_cnt counts cycles with mem_req=1 and no mem_ack, and clears on every grant.
  - When wait_cnt reaches TIMEOUT_CYC-1 without ack, the next cycle brings: mem_req=0, bus_err=1, and the completion pulse for the owner.
    - DATA: dm_done=1 with dm_rdata=0.
    - FETCH: if_valid=1 with if_rdata=0.
    - FETCH_DROP: no completion pulse.
  - The state then returns to IDLE.
  - If mem_ack and the timeout hit coincide, the ack wins.
- A mem_ack received in IDLE is ignored.

Decomposition:
- State encodings (ARB_IDLE/DATA/FETCH/FETCH_DROP, 2-bit) go as macros in ctrl_encode_def.v alongside the existing NPC/opcode defines.
- One natural sub-module: arb_wait_timer, holding wait_cnt, its clear/enable logic and the expiry compare, parameterised by TIMEOUT_CYC.

Test Plan:
1. Zero-wait load: dm_req=1, dm_addr=0x100, dm_we=0, memory acks in cycle 1 with 0xDEADBEEF -> mem_req high in cycle 1 only, dm_done and dm_rdata=0xDEADBEEF in cycle 2; stall_mem high in cycles 0-1.
2. Contention: dm_req and if_req both raised in cycle 0 -> data is granted first and dm_done arrives in cycle 2; the fetch is granted in cycle 2 and if_valid arrives in cycle 4.
3. Starvation: dm_req held continuously across 5 data transactions with if_req=1 (FETCH_STARVE=4) -> the 5th grant goes to fetch; starve_cnt=0 afterwards.
4. Flush in flight: fetch 0x200 granted, memory acks after 3 cycles, if_flush pulsed in the 2nd wait cycle -> state is FETCH_DROP, no if_valid, IDLE after the ack; an immediate fetch of 0x300 completes normally. Repeat with if_flush coincident with mem_ack -> response dropped.
5. Timeout: TIMEOUT_CYC=8, store with no ack -> mem_req high for 8 cycles, then bus_err=1 and dm_done=1 in the same cycle, mem_req=0, state IDLE.
6. Reset mid-op: rstn=0 while in DATA with mem_req=1 -> next edge mem_req=0, all outputs 0, state IDLE; after release, a new load completes in 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_DATA       = 2'd1,
        ARB_FETCH      = 2'd2,
        ARB_FETCH_DROP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Counts stalled cycles of an outstanding bus transaction and flags expiry.
module arb_wait_timer #(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rstn)
            wait_cnt <= '0;
        else if (clr)
            wait_cnt <= '0;
        else if (en)
            wait_cnt <= wait_cnt + W'(1);
    end

    // A zero timeout disables expiry entirely.
    assign expire = (TIMEOUT_CYC > 0) && en && (wait_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch and load/store,
// one outstanding transaction, data priority with fetch starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC  = 0,
    parameter int FETCH_STARVE = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam int SW = $clog2(FETCH_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE);

    arb_state_e    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          grant_d, grant_f, fin_d, fin_f, err, expire;

    arb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (grant_d | grant_f),
        .en     (mem_req & ~mem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        fin_d     = 1'b0;
        fin_f     = 1'b0;
        err       = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dm_req && (starve_cnt < STARVE_MAX || !if_req || if_flush)) begin
                    grant_d   = 1'b1;
                    state_nxt = ARB_DATA;
                end else if (if_req && !if_flush) begin
                    grant_f   = 1'b1;
                    state_nxt = ARB_FETCH;
                end
            end
            ARB_DATA: begin
                if (mem_ack || expire) begin
                    fin_d     = 1'b1;
                    err       = ~mem_ack;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_FETCH: begin
                // A flush without a response cannot cancel the bus cycle; park in DROP.
                if (mem_ack || expire) begin
                    fin_f     = ~if_flush;
                    err       = ~mem_ack;
                    state_nxt = ARB_IDLE;
                end else if (if_flush) begin
                    state_nxt = ARB_FETCH_DROP;
                end
            end
            ARB_FETCH_DROP: begin
                if (mem_ack || expire) begin
                    err       = ~mem_ack;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_done    <= 1'b0;
            bus_err    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_valid <= fin_f;
            dm_done  <= fin_d;
            bus_err  <= err;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_be    <= dm_be;
            end else if (grant_f) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                mem_be   <= 4'hF;
            end else if (state_nxt == ARB_IDLE) begin
                mem_req <= 1'b0;
            end
            if (fin_d && (err || !mem_we))
                dm_rdata <= err ? 32'd0 : mem_rdata;
            if (fin_f)
                if_rdata <= err ? 32'd0 : mem_rdata;
            if (grant_f)
                starve_cnt <= '0;
            else if (grant_d)
                starve_cnt <= !if_req ? '0 :
                              (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + SW'(1);
        end
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation, flush, timeout, reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, if_flush, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_done, mem_req, mem_we, stall_if, stall_mem, bus_err;
    logic [3:0]  mem_be;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(8), .FETCH_STARVE(4)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0; dm_be = 0;
        nxt(); nxt();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_flags", {28'd0, if_valid, dm_done, bus_err, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_rdata", dm_rdata | if_rdata, 0);
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_starve", 32'(dut.starve_cnt), 0);

        // 1: zero-wait load
        rstn = 1; dm_req = 1; dm_addr = 32'h100; dm_we = 0; dm_be = 4'hF; #1;
        chk("t1_stall_c0", 32'(stall_mem), 1);
        chk("t1_req_c0", 32'(mem_req), 0);
        nxt();
        chk("t1_req_c1", 32'(mem_req), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_stall_c1", 32'(stall_mem), 1);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        nxt();
        mem_ack = 0;
        chk("t1_done", 32'(dm_done), 1);
        chk("t1_rdata", dm_rdata, 32'hDEADBEEF);
        chk("t1_req_c2", 32'(mem_req), 0);
        chk("t1_stall_c2", 32'(stall_mem), 0);
        dm_req = 0;
        nxt();
        chk("t1_done_c3", 32'(dm_done), 0);

        // 2: contention, store first then fetch
        dm_req = 1; dm_we = 1; dm_addr = 32'h104; dm_wdata = 32'h1234; dm_be = 4'h3;
        if_req = 1; if_addr = 32'h40; #1;
        chk("t2_stall_if", 32'(stall_if), 1);
        nxt();
        chk("t2_d_addr", mem_addr, 32'h104);
        chk("t2_d_we", 32'(mem_we), 1);
        chk("t2_d_be", 32'(mem_be), 32'h3);
        chk("t2_d_wdata", mem_wdata, 32'h1234);
        mem_ack = 1; mem_rdata = 32'hAAAA5555;
        nxt();
        mem_ack = 0;
        chk("t2_done", 32'(dm_done), 1);
        chk("t2_st_hold", dm_rdata, 32'hDEADBEEF);
        chk("t2_if_c2", 32'(if_valid), 0);
        dm_req = 0; dm_we = 0;
        nxt();
        chk("t2_f_req", 32'(mem_req), 1);
        chk("t2_f_addr", mem_addr, 32'h40);
        chk("t2_f_be", {27'd0, mem_we, mem_be}, 32'hF);
        mem_ack = 1; mem_rdata = 32'h00000013;
        nxt();
        mem_ack = 0;
        chk("t2_ifv", 32'(if_valid), 1);
        chk("t2_ifd", if_rdata, 32'h13);
        chk("t2_stall_if_c4", 32'(stall_if), 0);
        if_req = 0;
        nxt();
        chk("t2_ifv_c5", 32'(if_valid), 0);

        // 3: starvation guard, back-to-back loads with a pending fetch
        dm_req = 1; dm_addr = 32'h500; dm_be = 4'hF; if_req = 1; if_addr = 32'h600;
        for (int k = 0; k < 5; k++) begin
            nxt();
            chk($sformatf("t3_addr%0d", k), mem_addr, (k < 4) ? 32'h500 : 32'h600);
            chk($sformatf("t3_starve%0d", k), 32'(dut.starve_cnt), (k < 4) ? k + 1 : 0);
            mem_ack = 1; mem_rdata = k;
            nxt();
            mem_ack = 0;
            if (k < 4) begin
                chk($sformatf("t3_done%0d", k), {30'd0, dm_done, if_valid}, 32'h2);
                chk($sformatf("t3_rd%0d", k), dm_rdata, k);
            end else begin
                chk("t3_fetch", {30'd0, dm_done, if_valid}, 32'h1);
                chk("t3_fetch_rd", if_rdata, 32'd4);
                dm_req = 0; if_req = 0;
            end
        end
        nxt();
        chk("t3_idle", {29'd0, mem_req, dut.state}, 0);

        // 4a: flush while the fetch waits; response is swallowed
        if_req = 1; if_addr = 32'h200;
        nxt();
        chk("t4_req", mem_addr, 32'h200);
        nxt();
        if_flush = 1; if_addr = 32'h300;
        nxt();
        if_flush = 0;
        chk("t4_drop_st", 32'(dut.state), 32'(3));
        chk("t4_drop_req", 32'(mem_req), 1);
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        nxt();
        mem_ack = 0;
        chk("t4_no_ifv", 32'(if_valid), 0);
        chk("t4_idle", {29'd0, mem_req, dut.state}, 0);
        nxt();
        chk("t4_refetch", mem_addr, 32'h300);
        mem_ack = 1; mem_rdata = 32'h300;
        nxt();
        mem_ack = 0;
        chk("t4_refetch_v", 32'(if_valid), 1);
        chk("t4_refetch_d", if_rdata, 32'h300);
        if_req = 0;
        // 4b: flush coincident with ack
        nxt();
        if_req = 1; if_addr = 32'h400;
        nxt();
        chk("t4b_addr", mem_addr, 32'h400);
        mem_ack = 1; if_flush = 1; mem_rdata = 32'hBAD2;
        nxt();
        mem_ack = 0; if_flush = 0; if_req = 0;
        chk("t4b_no_ifv", 32'(if_valid), 0);
        chk("t4b_hold", if_rdata, 32'h300);
        chk("t4b_idle", {29'd0, mem_req, dut.state}, 0);

        // 5: store that never gets acked
        nxt();
        dm_req = 1; dm_we = 1; dm_addr = 32'h700; dm_wdata = 32'h55;
        for (int i = 1; i <= 8; i++) begin
            nxt();
            chk($sformatf("t5_req%0d", i), {30'd0, mem_req, bus_err}, 32'h2);
        end
        nxt();
        chk("t5_err", {29'd0, mem_req, bus_err, dm_done}, 32'h3);
        chk("t5_rdata", dm_rdata, 0);
        chk("t5_state", 32'(dut.state), 0);
        dm_req = 0; dm_we = 0;
        nxt();
        chk("t5_err_pulse", 32'(bus_err), 0);

        // 6: reset during an outstanding load
        dm_req = 1; dm_addr = 32'h800;
        nxt();
        chk("t6_req", 32'(mem_req), 1);
        rstn = 0;
        nxt();
        chk("t6_rst_req", {29'd0, mem_req, dut.state}, 0);
        chk("t6_rst_out", mem_addr | dm_rdata | if_rdata | {28'd0, mem_be}, 0);
        rstn = 1;
        nxt();
        chk("t6_req2", mem_addr, 32'h800);
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        nxt();
        mem_ack = 0;
        chk("t6_done", 32'(dm_done), 1);
        chk("t6_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
